// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, defaults and helpers for the round-robin grant arbiter
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N_DEFAULT = 16;

    // Binary index of a one-hot vector; an all-zero input returns 0.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] onehot);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: rotate by ptr, lowest-bit encode, un-rotate
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = ARB_N_DEFAULT,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             found
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] iso_dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   iso;

    always_comb begin
        req_dbl    = {req, req} >> ptr;
        rot        = req_dbl[N-1:0];
        // Isolate the lowest set bit of the rotated vector (two's complement trick).
        iso        = rot & (~rot + N'(1));
        iso_dbl    = {iso, iso} << ptr;
        winner     = iso_dbl[2*N-1:N];
        winner_idx = IDX_W'(onehot_to_idx(32'(winner)));
        found      = |req;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - registered round-robin arbiter with hold-until-release
// Optional hold limit with preemption is enabled by defining ARB_HOLD_LIMIT_EN.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEFAULT,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             release_i,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             any_req,
    output logic             preempt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    arb_state_t       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             preempt_q, preempt_d;

    logic [N-1:0]     pick_winner;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [IDX_W-1:0] next_ptr;
    logic             owner_done;
    logic             force_release;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .winner     (pick_winner),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    assign next_ptr   = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);
    assign owner_done = release_i | ~req[grant_idx_q];

`ifdef ARB_HOLD_LIMIT_EN
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // Preempt only when someone else is actually waiting.
    assign force_release = (hold_cnt_q == HOLD_MAX) && (|(req & ~grant_q));
`else
    logic [31:0] unused_max_hold;
    assign unused_max_hold = 32'(MAX_HOLD);
    assign force_release   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        preempt_d   = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d     = ARB_GRANT;
                    grant_d     = pick_winner;
                    grant_idx_d = pick_idx;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_d  = HOLD_W'(1);
`endif
                end
            end
            ARB_GRANT: begin
                if (owner_done || force_release) begin
                    state_d     = ARB_IDLE;
                    grant_d     = '0;
                    grant_idx_d = '0;
                    ptr_d       = next_ptr;
                    preempt_d   = force_release & ~owner_done;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_d  = '0;
`endif
                end else begin
`ifdef ARB_HOLD_LIMIT_EN
                    if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            preempt_q   <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            preempt_q   <= preempt_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = |grant_q;
    assign any_req     = pick_found;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed scoreboard bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             release_i;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             any_req;
    logic             preempt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mptr   = 0;
    int mowner = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(
        .N        (N),
        .IDX_W    (IDX_W),
        .MAX_HOLD (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .release_i   (release_i),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .any_req     (any_req),
        .preempt     (preempt)
    );

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic arm(input logic [N-1:0] r);
        req = r;
        exp_q.push_back(model_pick(r, mptr));
    endtask

    task automatic check_grant(input string tag);
        int e;
        logic [N-1:0] oh;
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e  = exp_q.pop_front();
            oh = N'(1) << e;
            chk({tag, "_idx"}, 32'(grant_idx), 32'(e));
            chk({tag, "_onehot"}, 32'(grant), 32'(oh));
            chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
            mowner = e;
        end
    endtask

    task automatic do_release(input string tag);
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        chk({tag, "_bubble_valid"}, 32'(grant_valid), 32'd0);
        chk({tag, "_bubble_grant"}, 32'(grant), 32'd0);
        mptr = (mowner + 1) % N;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        release_i = 1'b0;
        #12;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_preempt", 32'(preempt), 32'd0);
        chk("rst_any_req", 32'(any_req), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1) single requester, one-cycle latency, release
        arm(16'h0001);
        #1 chk("t1_any_req", 32'(any_req), 32'd1);
        step();
        check_grant("t1");
        req = '0;
        do_release("t1");
        step();
        chk("t1_idle_stays", 32'(grant_valid), 32'd0);

        // 2) all requesting, release every grant
        arm(16'hFFFF);
        for (int k = 0; k < 17; k++) begin
            step();
            check_grant("t2");
            if (k == 16) req = '0;
            do_release("t2");
            if (k < 16) arm(16'hFFFF);
        end

        // 3) wrap-around from ptr 15, non-owner requests ignored
        arm(16'h4000);
        step();
        check_grant("t3_setup");
        req = '0;
        do_release("t3_setup");
        arm(16'h8001);
        step();
        check_grant("t3_top");
        req = 16'hFFFF;
        step();
        chk("t3_nonowner_hold", 32'(grant_idx), 32'd15);
        req = 16'h8001;
        do_release("t3_top");
        arm(16'h8001);
        step();
        check_grant("t3_wrap");
        req = '0;
        do_release("t3_wrap");

        // 4) owner drops its request without release_i
        arm(16'h0008);
        step();
        check_grant("t4_own3");
        req = '0;
        step();
        chk("t4_drop_valid", 32'(grant_valid), 32'd0);
        mptr = (mowner + 1) % N;
        arm(16'h0010);
        step();
        check_grant("t4_own4");
        req = '0;
        do_release("t4_own4");

        // 5) async reset mid-grant restarts ptr at 0
        arm(16'h0080);
        step();
        check_grant("t5_pre");
        step();
        chk("t5_held", 32'(grant_idx), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(grant), 32'd0);
        chk("t5_async_valid", 32'(grant_valid), 32'd0);
        chk("t5_async_idx", 32'(grant_idx), 32'd0);
        mptr = 0;
        req  = 16'h0081;
        step();
        rst_n = 1'b1;
        exp_q.push_back(model_pick(req, mptr));
        step();
        check_grant("t5_ptr0");
        req = '0;
        do_release("t5_ptr0");
        release_i = 1'b1;
        arm(16'h0080);
        step();
        release_i = 1'b0;
        check_grant("t5_idle_release_ignored");
        step();
        chk("t5_hold7", 32'(grant_idx), 32'd7);
        req = '0;
        do_release("t5_own7");

        // 6) hold behaviour with two requesters and no release
        arm(16'h0003);
        step();
        check_grant("t6_first");
`ifdef ARB_HOLD_LIMIT_EN
        for (int c = 2; c <= 8; c++) begin
            step();
            chk("t6_hold_idx", 32'(grant_idx), 32'd0);
            chk("t6_hold_preempt", 32'(preempt), 32'd0);
        end
        step();
        chk("t6_preempt_valid", 32'(grant_valid), 32'd0);
        chk("t6_preempt_pulse", 32'(preempt), 32'd1);
        mptr = (mowner + 1) % N;
        exp_q.push_back(model_pick(req, mptr));
        step();
        check_grant("t6_after_preempt");
        chk("t6_preempt_cleared", 32'(preempt), 32'd0);
        req = 16'h0001;
        do_release("t6_after_preempt");
        arm(16'h0001);
        step();
        check_grant("t6_solo");
`endif
        for (int c = 0; c < 20; c++) begin
            step();
            chk("t6_forever_idx", 32'(grant_idx), 32'd0);
            chk("t6_forever_valid", 32'(grant_valid), 32'd1);
            chk("t6_no_preempt", 32'(preempt), 32'd0);
        end
        req = '0;
        do_release("t6_end");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
